ama_riscv_hazard_unit: RTL
==========================

Name: ama_riscv_hazard_unit

Overview:
- Parametrised successor of the control-path forwarding logic. Tracks in-flight register writers in a shift-register scoreboard covering NUM_FWD post-ID stages.
- Produces per-operand forward selects, detects load-use hazards with configurable load latency, and inserts bubbles.
- Supports pipeline freeze while a multi-cycle unit is busy, and EX-redirect flushes.
- Sits in the control block between the decoder (ID-stage info) and the datapath forward muxes.

Parameters:
- NUM_FWD, 2, number of post-ID stages that can forward (stage 1 = EX, stage NUM_FWD = last before regfile write-through); range 1..4.
- LOAD_LAT, 1, extra stages after EX before load data is forwardable; range 0..NUM_FWD-1.
- REG_AW, 5, register address width.
- SEL_W, clog2(NUM_FWD+1), forward-select width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- id_valid  in  1  ID holds a real instruction.
- rs1_id  in  REG_AW  ID source 1.
- rs2_id  in  REG_AW  ID source 2.
- rs1_used  in  1  ID instruction reads rs1.
- rs2_used  in  1  ID instruction reads rs2.
- reg_we_id  in  1  ID instruction writes rd.
- rd_id  in  REG_AW  ID destination.
- load_inst_id  in  1  ID instruction is a load.
- ex_flush  in  1  EX redirect (taken branch/jump); kills IF and ID.
- mc_busy  in  1  multi-cycle unit busy; freezes whole pipe.
- alu_a_sel_fwd  out  SEL_W  0 = regfile/decoder select, k = forward from stage k.
- alu_b_sel_fwd  out  SEL_W  same, for rs2.
- stall_if  out  1  hold PC/IF.
- stall_id  out  1  hold ID register.
- bubble_ex  out  1  insert NOP into EX.
- clear_if  out  1  flush IF.
- clear_id  out  1  flush ID.
- stall_cnt  out  32  saturating count of load-use stall cycles.

Behaviour:
- Scoreboard: NUM_FWD entries {v, we, rd, ld}, entry 1 = EX.
- On reset, all entries v=0 and stall_cnt=0. Every output is then 0 for any input, except clear_if/clear_id, which follow ex_flush.
- Advance, when mc_busy=0:
  - entry[k+1] <= entry[k].
  - entry[1] <= ID instruction if id_valid & !hazard & !ex_flush; otherwise a bubble (v=0).
  - The oldest entry retires.
- mc_busy=1: scoreboard holds; stall_if=stall_id=1; bubble_ex=0; stall_cnt holds; ex_flush is ignored (the source must hold it until mc_busy drops).
- Match for operand X at stage k: rsX_used & v[k] & we[k] & rd[k]==rsX & rsX!=0.
- Priority: the smallest k (youngest) wins; no match gives sel 0. Selects are combinational from the current scoreboard and ID fields (zero latency).
- Hazard: the winning match for either used operand has ld[k]=1 and k<=LOAD_LAT.
  - Outputs: stall_if=stall_id=bubble_ex=1. The sel for that operand is forced to 0 that cycle.
  - The hazard clears automatically once the load ages past stage LOAD_LAT (LOAD_LAT-k+1 stall cycles).
  - stall_cnt increments by 1 per hazard cycle and saturates at 32'hFFFF_FFFF.
- ex_flush=1 with mc_busy=0: clear_if=clear_id=1; hazard is suppressed (stalls=0, counter not incremented); entry[1] gets a bubble. The flushing instruction in EX advances normally.
- A writer whose distance exceeds NUM_FWD is served by regfile write-through; no select.
- Reset asserted mid-operation: scoreboard and counter clear immediately (async); pending stalls drop the same instant.
- id_valid=0: no hazard, and any selects are don't-care.

Decomposition:
- Package/defines: forward-select encoding constants (FWD_RF=0, FWD_EX=1, …), scoreboard entry field widths.
- Sub-module: ama_riscv_fwd_match, a per-operand priority matcher returning {sel, hazard}; instantiated once for rs1 and once for rs2.

Test Plan:
- Reset: drive rst=0 mid-stream with a load in EX -> all outputs 0 immediately; stall_cnt=0; first post-reset cycle has no stall.
- ALU chain, NUM_FWD=2: add x5 in ID at cycle 0, then rs1=x5 at cycle 1 -> alu_a_sel_fwd=1, no stall. At cycle 2 (distance 2) -> sel=2. At distance 3 -> sel=0.
- Load-use, LOAD_LAT=1: lw x7 followed by add rs2=x7 -> exactly 1 cycle of stall_if=stall_id=bubble_ex=1 with alu_b_sel_fwd=0. Next cycle alu_b_sel_fwd=2; stall_cnt=1.
- x0 and priority: writer rd=x0 -> sel 0, no stall. x3 in stages 1 and 2 with rs1=rs2=x3 -> both sels=1.
- Flush plus hazard: load-use hazard coincident with ex_flush=1 -> clear_if=clear_id=1, stalls 0, stall_cnt unchanged, entry 1 is a bubble next cycle.
- Freeze: mc_busy=1 for 3 cycles with x9 in stage 1 -> sel stays 1 all 3 cycles; stall_if=stall_id=1; stall_cnt unchanged; ex_flush pulsed during busy is ignored.

Source files
------------

// File: rtl/ama_riscv_hazard_unit_pkg.sv
// Shared constants for the hazard unit: forward-select encoding, scoreboard field
// widths and the saturating stall-counter helper.
package ama_riscv_hazard_unit_pkg;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  localparam int SB_V_W  = 1;
  localparam int SB_WE_W = 1;
  localparam int SB_LD_W = 1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ama_riscv_hazard_unit_fwd_match.sv
// Per-operand priority matcher: finds the youngest in-flight writer of rs and
// reports either its forward stage or a load-use hazard.
module ama_riscv_fwd_match
  import ama_riscv_hazard_unit_pkg::*;
#(
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5,
  parameter int SEL_W    = 2
) (
  input  logic                      used,
  input  logic [REG_AW-1:0]         rs,
  input  logic [NUM_FWD-1:0]        v,
  input  logic [NUM_FWD-1:0]        we,
  input  logic [NUM_FWD-1:0]        ld,
  input  logic [NUM_FWD*REG_AW-1:0] rd,
  output logic [SEL_W-1:0]          sel,
  output logic                      hazard
);

  // Oldest stage evaluated first so the youngest match overwrites it.
  always_comb begin
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (used && (rs != '0) && v[k-1] && we[k-1] &&
          (rd[(k-1)*REG_AW +: REG_AW] == rs)) begin
        if (ld[k-1] && (k <= LOAD_LAT)) begin
          sel    = SEL_W'(FWD_RF);
          hazard = 1'b1;
        end else begin
          sel    = SEL_W'(k);
          hazard = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ama_riscv_hazard_unit.sv
// Hazard unit: shift-register scoreboard of in-flight writers driving forward
// selects, load-use stalls, freeze on multi-cycle busy and EX-redirect flushes.
module ama_riscv_hazard_unit
  import ama_riscv_hazard_unit_pkg::*;
#(
  parameter  int NUM_FWD  = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int REG_AW   = 5,
  localparam int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              reg_we_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              load_inst_id,
  input  logic              ex_flush,
  input  logic              mc_busy,
  output logic [SEL_W-1:0]  alu_a_sel_fwd,
  output logic [SEL_W-1:0]  alu_b_sel_fwd,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              clear_if,
  output logic              clear_id,
  output logic [31:0]       stall_cnt
);

  // Index 0 is stage 1 (EX); index NUM_FWD-1 is the oldest forwardable stage.
  logic [NUM_FWD-1:0]        sb_v;
  logic [NUM_FWD-1:0]        sb_we;
  logic [NUM_FWD-1:0]        sb_ld;
  logic [NUM_FWD*REG_AW-1:0] sb_rd;

  logic             hz_a;
  logic             hz_b;
  logic             hz_raw;
  logic             hazard;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;

  ama_riscv_fwd_match #(
    .NUM_FWD (NUM_FWD),
    .LOAD_LAT(LOAD_LAT),
    .REG_AW  (REG_AW),
    .SEL_W   (SEL_W)
  ) u_match_rs1 (
    .used  (rs1_used),
    .rs    (rs1_id),
    .v     (sb_v),
    .we    (sb_we),
    .ld    (sb_ld),
    .rd    (sb_rd),
    .sel   (sel_a),
    .hazard(hz_a)
  );

  ama_riscv_fwd_match #(
    .NUM_FWD (NUM_FWD),
    .LOAD_LAT(LOAD_LAT),
    .REG_AW  (REG_AW),
    .SEL_W   (SEL_W)
  ) u_match_rs2 (
    .used  (rs2_used),
    .rs    (rs2_id),
    .v     (sb_v),
    .we    (sb_we),
    .ld    (sb_ld),
    .rd    (sb_rd),
    .sel   (sel_b),
    .hazard(hz_b)
  );

  assign hz_raw = id_valid & (hz_a | hz_b);
  assign hazard = hz_raw & ~ex_flush & ~mc_busy;

  // Stalls are gated by reset so they drop the instant reset asserts.
  assign stall_if      = rst & (mc_busy | hazard);
  assign stall_id      = rst & (mc_busy | hazard);
  assign bubble_ex     = rst & hazard;
  assign clear_if      = ex_flush & ~mc_busy;
  assign clear_id      = ex_flush & ~mc_busy;
  assign alu_a_sel_fwd = sel_a;
  assign alu_b_sel_fwd = sel_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v      <= '0;
      stall_cnt <= '0;
    end else if (!mc_busy) begin
      for (int k = NUM_FWD - 1; k >= 1; k--) begin
        sb_v[k] <= sb_v[k-1];
      end
      sb_v[0] <= id_valid & ~hz_raw & ~ex_flush;
      if (hazard) begin
        stall_cnt <= sat_inc32(stall_cnt);
      end
    end
  end

  // Payload fields are only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!mc_busy) begin
      for (int k = NUM_FWD - 1; k >= 1; k--) begin
        sb_we[k]                 <= sb_we[k-1];
        sb_ld[k]                 <= sb_ld[k-1];
        sb_rd[k*REG_AW +: REG_AW] <= sb_rd[(k-1)*REG_AW +: REG_AW];
      end
      sb_we[0]          <= reg_we_id;
      sb_ld[0]          <= load_inst_id;
      sb_rd[REG_AW-1:0] <= rd_id;
    end
  end

endmodule
